// File: rtl/csm_mem_responder_if.sv
// One CSM responder port: op request, address and write data in; ready, done strobe and response out.
interface csm_mem_responder_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              start;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output start, op, addr, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  start, op, addr, wdata,
        output ready, done, rdata, err
    );
endinterface

// File: rtl/csm_mem_responder.sv
// Dual-port CSM shared-memory responder with per-address hold/release locks.
// Optional CSM_HOLD_TIMEOUT_EN: locks auto-clear HOLD_TIMEOUT cycles after the last successful hold.
module csm_mem_responder #(
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 8,
    parameter int HOLD_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    csm_mem_responder_if.slave  a_if,
    csm_mem_responder_if.slave  b_if
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_HOLD    = 2'b10;
    localparam logic [1:0] OP_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } own_e;

    // Index 0 is port A, index 1 is port B throughout.
    logic              start_s [2];
    logic [1:0]        op_s    [2];
    logic [ADDR_W-1:0] addr_s  [2];
    logic [DATA_W-1:0] wdata_s [2];
    logic              acc_s   [2];
    logic              err_s   [2];
    logic [DATA_W-1:0] rdata_s [2];

    state_e            state_q [2];
    state_e            state_d [2];
    logic              ready_q [2];
    logic              done_q  [2];
    logic              err_q   [2];
    logic [DATA_W-1:0] rdata_q [2];

    own_e              owner_q [DEPTH];
    own_e              owner_d [DEPTH];
    logic [DATA_W-1:0] mem_q   [DEPTH];
    logic [DATA_W-1:0] mem_d   [DEPTH];

`ifdef CSM_HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q   [DEPTH];
    logic [CNT_W-1:0]  cnt_d   [DEPTH];
`endif

    function automatic own_e port_owner(input logic is_b);
        if (is_b) begin
            return OWN_B;
        end else begin
            return OWN_A;
        end
    endfunction

    assign start_s[0] = a_if.start;
    assign start_s[1] = b_if.start;
    assign op_s[0]    = a_if.op;
    assign op_s[1]    = b_if.op;
    assign addr_s[0]  = a_if.addr;
    assign addr_s[1]  = b_if.addr;
    assign wdata_s[0] = a_if.wdata;
    assign wdata_s[1] = b_if.wdata;

    assign a_if.ready = ready_q[0];
    assign a_if.done  = done_q[0];
    assign a_if.rdata = rdata_q[0];
    assign a_if.err   = err_q[0];
    assign b_if.ready = ready_q[1];
    assign b_if.done  = done_q[1];
    assign b_if.rdata = rdata_q[1];
    assign b_if.err   = err_q[1];

    // Per-port handshake FSM next state and accept decode
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            acc_s[p]   = 1'b0;
            case (state_q[p])
                S_INIT: state_d[p] = S_IDLE;
                S_IDLE: begin
                    if (start_s[p]) begin
                        state_d[p] = S_RESP;
                        acc_s[p]   = 1'b1;
                    end else begin
                        state_d[p] = S_IDLE;
                    end
                end
                S_RESP:  state_d[p] = S_IDLE;
                default: state_d[p] = S_INIT;
            endcase
        end
    end

    // Op execution against pre-edge memory and lock table; port A wins same-address write/hold races
    always_comb begin
        logic blocked_v;
        logic lost_v;
        owner_d = owner_q;
        mem_d   = mem_q;
`ifdef CSM_HOLD_TIMEOUT_EN
        cnt_d   = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (owner_q[i] == OWN_NONE) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (cnt_q[i] == CNT_W'(HOLD_TIMEOUT - 1)) begin
                owner_d[i] = OWN_NONE;
                cnt_d[i]   = {CNT_W{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
`endif
        for (int p = 0; p < 2; p++) begin
            err_s[p]   = 1'b0;
            rdata_s[p] = {DATA_W{1'b0}};
            blocked_v  = (owner_q[addr_s[p]] == port_owner(p == 0));
            lost_v     = (p == 1) && acc_s[0] && !err_s[0] && (addr_s[0] == addr_s[1])
                         && (op_s[0] == op_s[1])
                         && ((op_s[0] == OP_WRITE) || (op_s[0] == OP_HOLD));
            if (acc_s[p]) begin
                case (op_s[p])
                    OP_READ: begin
                        if (blocked_v) begin
                            err_s[p] = 1'b1;
                        end else begin
                            rdata_s[p] = mem_q[addr_s[p]];
                        end
                    end
                    OP_WRITE: begin
                        if (blocked_v || lost_v) begin
                            err_s[p] = 1'b1;
                        end else begin
                            mem_d[addr_s[p]] = wdata_s[p];
                        end
                    end
                    OP_HOLD: begin
                        if (blocked_v || lost_v) begin
                            err_s[p] = 1'b1;
                        end else begin
                            owner_d[addr_s[p]] = port_owner(p == 1);
`ifdef CSM_HOLD_TIMEOUT_EN
                            cnt_d[addr_s[p]] = {CNT_W{1'b0}};
`endif
                        end
                    end
                    OP_RELEASE: begin
                        if (owner_q[addr_s[p]] == port_owner(p == 1)) begin
                            owner_d[addr_s[p]] = OWN_NONE;
`ifdef CSM_HOLD_TIMEOUT_EN
                            cnt_d[addr_s[p]] = {CNT_W{1'b0}};
`endif
                        end else begin
                            err_s[p] = 1'b1;
                        end
                    end
                    default: err_s[p] = 1'b1;
                endcase
            end else begin
                err_s[p] = 1'b0;
            end
        end
    end

    // State, response registers, memory and lock table
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= S_INIT;
                ready_q[p] <= 1'b0;
                done_q[p]  <= 1'b0;
                err_q[p]   <= 1'b0;
                rdata_q[p] <= {DATA_W{1'b0}};
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]   <= {DATA_W{1'b0}};
                owner_q[i] <= OWN_NONE;
`ifdef CSM_HOLD_TIMEOUT_EN
                cnt_q[i]   <= {CNT_W{1'b0}};
`endif
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
                ready_q[p] <= (state_d[p] == S_IDLE);
                done_q[p]  <= acc_s[p];
                err_q[p]   <= err_s[p];
                rdata_q[p] <= rdata_s[p];
            end
            mem_q   <= mem_d;
            owner_q <= owner_d;
`ifdef CSM_HOLD_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_csm_mem_responder.sv
// Directed bench for csm_mem_responder: single-port ops, lock conflicts and same-edge races.
module tb_csm_mem_responder;
    localparam int HOLD_TIMEOUT = 16;
    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] HD = 2'b10;
    localparam logic [1:0] RL = 2'b11;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic       da, ea, db, eb;
    logic [7:0] ra, rb;

    csm_mem_responder_if #(.ADDR_W(3), .DATA_W(8)) a_if ();
    csm_mem_responder_if #(.ADDR_W(3), .DATA_W(8)) b_if ();

    csm_mem_responder #(.ADDR_W(3), .DATA_W(8), .HOLD_TIMEOUT(HOLD_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .a_if  (a_if),
        .b_if  (b_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue ops on both ports (each enabled by its en flag) at the same edge; capture the response cycle.
    task automatic dual(input logic en_a, input logic [1:0] op_a, input logic [2:0] ad_a, input logic [7:0] wd_a,
                        input logic en_b, input logic [1:0] op_b, input logic [2:0] ad_b, input logic [7:0] wd_b);
        if (en_a) chk("a_ready_before_op", 32'(a_if.ready), 32'd1);
        if (en_b) chk("b_ready_before_op", 32'(b_if.ready), 32'd1);
        a_if.start = en_a; a_if.op = op_a; a_if.addr = ad_a; a_if.wdata = wd_a;
        b_if.start = en_b; b_if.op = op_b; b_if.addr = ad_b; b_if.wdata = wd_b;
        tick();
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        da = a_if.done; ea = a_if.err; ra = a_if.rdata;
        db = b_if.done; eb = b_if.err; rb = b_if.rdata;
        tick();
    endtask

    task automatic op_a(input logic [1:0] op, input logic [2:0] ad, input logic [7:0] wd);
        dual(1'b1, op, ad, wd, 1'b0, RD, 3'd0, 8'h00);
    endtask

    task automatic op_b(input logic [1:0] op, input logic [2:0] ad, input logic [7:0] wd);
        dual(1'b0, RD, 3'd0, 8'h00, 1'b1, op, ad, wd);
    endtask

    initial begin
        reset = 1'b1;
        a_if.start = 1'b0; a_if.op = RD; a_if.addr = 3'd0; a_if.wdata = 8'h00;
        b_if.start = 1'b0; b_if.op = RD; b_if.addr = 3'd0; b_if.wdata = 8'h00;
        tick();
        tick();
        chk("rst_a_ready", 32'(a_if.ready), 32'd0);
        chk("rst_b_ready", 32'(b_if.ready), 32'd0);
        chk("rst_a_done",  32'(a_if.done),  32'd0);
        chk("rst_b_err",   32'(b_if.err),   32'd0);
        chk("rst_a_rdata", 32'(a_if.rdata), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_a_ready", 32'(a_if.ready), 32'd1);
        chk("post_rst_b_ready", 32'(b_if.ready), 32'd1);

        // T1: write then read back
        op_a(WR, 3'd3, 8'hA5);
        chk("t1_wr_done", 32'(da), 32'd1);
        chk("t1_wr_err",  32'(ea), 32'd0);
        chk("t1_wr_rdata_zero", 32'(ra), 32'd0);
        chk("t1_done_drops", 32'(a_if.done), 32'd0);
        op_a(RD, 3'd3, 8'h00);
        chk("t1_rd_done",  32'(da), 32'd1);
        chk("t1_rd_rdata", 32'(ra), 32'hA5);
        chk("t1_rd_err",   32'(ea), 32'd0);
        chk("t1_rdata_idle_zero", 32'(a_if.rdata), 32'd0);
        op_b(RD, 3'd0, 8'h00);
        chk("mem_reset_zero", 32'(rb), 32'd0);

        // T2: A holds 2; B access refused; data untouched
        op_a(WR, 3'd2, 8'h77);
        op_a(HD, 3'd2, 8'h00);
        chk("t2_hold_err", 32'(ea), 32'd0);
        op_b(RD, 3'd2, 8'h00);
        chk("t2_b_rd_err",   32'(eb), 32'd1);
        chk("t2_b_rd_rdata", 32'(rb), 32'd0);
        chk("t2_b_rd_done",  32'(db), 32'd1);
        op_b(WR, 3'd2, 8'h11);
        chk("t2_b_wr_err", 32'(eb), 32'd1);
        op_a(RD, 3'd2, 8'h00);
        chk("t2_a_rd_old", 32'(ra), 32'h77);
        chk("t2_a_rd_err", 32'(ea), 32'd0);

        // T3: re-hold, release, then foreign release
        op_a(HD, 3'd2, 8'h00);
        chk("t3_rehold_err", 32'(ea), 32'd0);
        op_a(RL, 3'd2, 8'h00);
        chk("t3_rel_err", 32'(ea), 32'd0);
        op_b(RD, 3'd2, 8'h00);
        chk("t3_b_rd_err",   32'(eb), 32'd0);
        chk("t3_b_rd_rdata", 32'(rb), 32'h77);
        op_b(RL, 3'd2, 8'h00);
        chk("t3_b_rel_free_err", 32'(eb), 32'd1);

        // T4: same-edge write collision, A wins
        dual(1'b1, WR, 3'd5, 8'hFF, 1'b1, WR, 3'd5, 8'h00);
        chk("t4_a_err", 32'(ea), 32'd0);
        chk("t4_b_err", 32'(eb), 32'd1);
        chk("t4_b_done", 32'(db), 32'd1);
        op_b(RD, 3'd5, 8'h00);
        chk("t4_mem5", 32'(rb), 32'hFF);

        // T5: read sees pre-edge data while other port writes
        dual(1'b1, RD, 3'd7, 8'h00, 1'b1, WR, 3'd7, 8'h3C);
        chk("t5_a_rdata", 32'(ra), 32'h00);
        chk("t5_a_err",   32'(ea), 32'd0);
        chk("t5_b_err",   32'(eb), 32'd0);
        op_a(RD, 3'd7, 8'h00);
        chk("t5_a_rd_new", 32'(ra), 32'h3C);

        // Same-edge hold race on a free address, A wins
        dual(1'b1, HD, 3'd4, 8'h00, 1'b1, HD, 3'd4, 8'h00);
        chk("hh_a_err", 32'(ea), 32'd0);
        chk("hh_b_err", 32'(eb), 32'd1);
        op_b(RL, 3'd4, 8'h00);
        chk("hh_b_rel_err", 32'(eb), 32'd1);
        op_a(RL, 3'd4, 8'h00);
        chk("hh_a_rel_err", 32'(ea), 32'd0);

        // B owns 6: A write refused; independent addresses proceed together
        op_b(HD, 3'd6, 8'h00);
        op_a(WR, 3'd6, 8'h99);
        chk("b_own_a_wr_err", 32'(ea), 32'd1);
        dual(1'b1, WR, 3'd1, 8'h12, 1'b1, WR, 3'd6, 8'h34);
        chk("indep_a_err", 32'(ea), 32'd0);
        chk("indep_b_err", 32'(eb), 32'd0);
        op_b(RL, 3'd6, 8'h00);
        chk("b_rel6_err", 32'(eb), 32'd0);
        op_a(RD, 3'd6, 8'h00);
        chk("mem6", 32'(ra), 32'h34);

        // Hold by A and write by B at the same edge both succeed
        dual(1'b1, HD, 3'd0, 8'h00, 1'b1, WR, 3'd0, 8'h5E);
        chk("hw_a_err", 32'(ea), 32'd0);
        chk("hw_b_err", 32'(eb), 32'd0);
        op_b(RD, 3'd0, 8'h00);
        chk("hw_b_rd_err", 32'(eb), 32'd1);
        op_a(RD, 3'd0, 8'h00);
        chk("hw_a_rd", 32'(ra), 32'h5E);
        op_a(RL, 3'd0, 8'h00);

        // T6: lock on 1 left idle past the timeout
        op_a(HD, 3'd1, 8'h00);
        chk("t6_hold_err", 32'(ea), 32'd0);
        repeat (HOLD_TIMEOUT + 1) tick();
        op_b(WR, 3'd1, 8'h66);
`ifdef CSM_HOLD_TIMEOUT_EN
        chk("t6_b_wr_err", 32'(eb), 32'd0);
        op_a(RL, 3'd1, 8'h00);
        chk("t6_a_rel_err", 32'(ea), 32'd1);
        op_a(RD, 3'd1, 8'h00);
        chk("t6_mem1", 32'(ra), 32'h66);
`else
        chk("t6_b_wr_err", 32'(eb), 32'd1);
        op_a(RL, 3'd1, 8'h00);
        chk("t6_a_rel_err", 32'(ea), 32'd0);
        op_a(RD, 3'd1, 8'h00);
        chk("t6_mem1", 32'(ra), 32'h12);
`endif

        // Reset clears memory and locks
        op_a(HD, 3'd3, 8'h00);
        reset = 1'b1;
        tick();
        chk("rst2_a_ready", 32'(a_if.ready), 32'd0);
        reset = 1'b0;
        tick();
        op_b(RD, 3'd3, 8'h00);
        chk("rst2_b_rd_err",   32'(eb), 32'd0);
        chk("rst2_b_rd_rdata", 32'(rb), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
